// File: rtl/animation_ladder_ctl_pkg.sv
// animation_pkg: shared state encoding and default timing for the ladder reveal
package animation_pkg;
    typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} anim_state_t;
    localparam int unsigned START_COUNT_DEF        = 15;
    localparam int unsigned START_DELAY_FRAMES_DEF = 30;
    localparam int unsigned FRAMES_PER_STEP_DEF    = 8;
    localparam int          FRAME_CNT_W            = 8;
endpackage

// File: rtl/animation_ladder_ctl_if.sv
// animation_ladder_ctl_if: game-control handshake and renderer outputs of the ladder reveal
interface animation_ladder_ctl_if;
    logic       game_en;
    logic       vblnk;
    logic       skip;
    logic       animation;
    logic [3:0] counter;
    logic       done;
    modport master (output game_en, vblnk, skip, input animation, counter, done);
    modport slave  (input game_en, vblnk, skip, output animation, counter, done);
endinterface

// File: rtl/animation_ladder_ctl_frame_tick_gen.sv
// frame_tick_gen: one-cycle frame tick on each rising edge of vblnk
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic vblnk,
    output logic tick
);
    logic vblnk_dly_q, vblnk_dly_d;

    always_comb vblnk_dly_d = vblnk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vblnk_dly_q <= 1'b0;
        else        vblnk_dly_q <= vblnk_dly_d;
    end

    assign tick = vblnk & ~vblnk_dly_q;
endmodule

// File: rtl/animation_ladder_ctl.sv
// animation_ladder_ctl: sequences the startup ladder reveal from frame ticks
module animation_ladder_ctl
    import animation_pkg::*;
#(
    parameter int unsigned START_COUNT        = START_COUNT_DEF,
    parameter int unsigned START_DELAY_FRAMES = START_DELAY_FRAMES_DEF,
    parameter int unsigned FRAMES_PER_STEP    = FRAMES_PER_STEP_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    animation_ladder_ctl_if.slave bus
);
    localparam logic [3:0]             START_CNT  = 4'(START_COUNT);
    localparam logic [FRAME_CNT_W-1:0] DELAY_LAST = FRAME_CNT_W'(START_DELAY_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] STEP_LAST  = FRAME_CNT_W'(FRAMES_PER_STEP - 1);

    anim_state_t            state_q, state_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]             counter_q, counter_d;
    logic                   animation_q, animation_d;
    logic                   done_q, done_d;
    logic                   tick, active, last, step;

    frame_tick_gen u_tick (.clk(clk), .rst_n(rst_n), .vblnk(bus.vblnk), .tick(tick));

    always_comb begin
        active = state_q == DELAY || state_q == RUN;
        last   = frame_cnt_q == (state_q == DELAY ? DELAY_LAST : STEP_LAST);
        step   = state_q == RUN && tick && last && counter_q != 4'd0;
        state_d = state_q;
        if (!bus.game_en)                    state_d = IDLE;
        else if (active && bus.skip)         state_d = DONE;
        else if (state_q == IDLE)            state_d = DELAY;
        else if (active && tick && last && !step) state_d = state_q == DELAY ? RUN : DONE;
        // a step or any state change restarts the frame count
        frame_cnt_d = (state_d != state_q || step) ? '0 :
                      (active && tick)             ? frame_cnt_q + 1'b1 : frame_cnt_q;
        counter_d   = state_d == DONE ? 4'd0 :
                      state_d == RUN  ? counter_q - {3'd0, step} : START_CNT;
        animation_d = state_d == DELAY || state_d == RUN;
        done_d      = state_d == DONE && state_q != DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            counter_q   <= START_CNT;
            animation_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            counter_q   <= counter_d;
            animation_q <= animation_d;
            done_q      <= done_d;
        end
    end

    assign bus.animation = animation_q;
    assign bus.counter   = counter_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_animation_ladder_ctl.sv
// tb_animation_ladder_ctl: vector table, corner sequences and random run against a tick-count model
module tb_animation_ladder_ctl;
    localparam int SC = 3, SD = 2, FPS = 2;
    localparam int TOTAL = SD + (SC + 1) * FPS;

    typedef struct {
        logic       ge, vb, sk, a;
        logic [3:0] c;
        logic       d;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    int   total = 0, bad = 0;
    int   m_t = 0;
    bit   m_act = 0, m_fin = 0, m_vprev = 0, m_pulse = 0;
    vec_t tbl[28];
    int   full_exp[10] = '{3, 3, 3, 3, 2, 2, 1, 1, 0, 0};
    logic vb_r;

    animation_ladder_ctl_if bus ();

    animation_ladder_ctl #(.START_COUNT(SC), .START_DELAY_FRAMES(SD), .FRAMES_PER_STEP(FPS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input bit ge, vb, sk, a, input int c, input bit d);
        vec_t v;
        v.ge = ge; v.vb = vb; v.sk = sk; v.a = a; v.c = 4'(c); v.d = d;
        return v;
    endfunction

    // reveal modelled as ticks elapsed since the reveal began
    function automatic int m_cnt();
        int k;
        if (m_fin) return 0;
        if (!m_act || m_t < SD) return SC;
        k = (m_t - SD) / FPS;
        return SC - (k > SC ? SC : k);
    endfunction

    function automatic void m_step(input bit ge, vb, sk);
        bit tk;
        tk = vb && !m_vprev;
        m_vprev = vb;
        m_pulse = 0;
        if (!ge) begin
            m_act = 0; m_fin = 0;
        end else if (m_act && sk) begin
            m_act = 0; m_fin = 1; m_pulse = 1;
        end else if (m_act) begin
            if (tk) begin
                m_t++;
                if (m_t == TOTAL) begin m_act = 0; m_fin = 1; m_pulse = 1; end
            end
        end else if (!m_fin) begin
            m_act = 1; m_t = 0;
        end
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic ge, vb, sk);
        bus.game_en = ge; bus.vblnk = vb; bus.skip = sk;
        @(posedge clk);
        m_step(ge, vb, sk);
        #1;
        chk("model_anim", bus.animation, m_act);
        chk("model_cnt", bus.counter, m_cnt());
        chk("model_done", bus.done, m_pulse);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.game_en = 1'b0; bus.vblnk = 1'b0; bus.skip = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_anim", bus.animation, 0);
        chk("rst_cnt", bus.counter, SC);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        m_act = 0; m_fin = 0; m_vprev = 0; m_t = 0; m_pulse = 0;
    endtask

    task automatic frame_rest();
        repeat (9) cyc(1'b1, 1'b1, 1'b0);
        repeat (90) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin cyc(1'b1, 1'b1, 1'b0); frame_rest(); end
    endtask

    task automatic full_run();
        cyc(1'b1, 1'b0, 1'b0);
        chk("full_start_anim", bus.animation, 1);
        chk("full_start_cnt", bus.counter, SC);
        for (int k = 1; k < 10; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk($sformatf("full_cnt_t%0d", k), bus.counter, full_exp[k]);
            chk($sformatf("full_anim_t%0d", k), bus.animation, 1);
            frame_rest();
        end
        cyc(1'b1, 1'b1, 1'b0);
        chk("full_done_pulse", bus.done, 1);
        chk("full_done_anim", bus.animation, 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("full_done_once", bus.done, 0);
        chk("full_done_cnt", bus.counter, 0);
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0, 1, 3, 0);
        tbl[1]  = mk(1, 1, 0, 1, 3, 0);
        tbl[2]  = mk(1, 0, 0, 1, 3, 0);
        tbl[3]  = mk(1, 1, 0, 1, 3, 0);
        tbl[4]  = mk(1, 0, 0, 1, 3, 0);
        tbl[5]  = mk(1, 1, 0, 1, 3, 0);
        tbl[6]  = mk(1, 0, 0, 1, 3, 0);
        tbl[7]  = mk(1, 1, 0, 1, 2, 0);
        tbl[8]  = mk(1, 0, 0, 1, 2, 0);
        tbl[9]  = mk(1, 1, 0, 1, 2, 0);
        tbl[10] = mk(1, 0, 0, 1, 2, 0);
        tbl[11] = mk(1, 1, 0, 1, 1, 0);
        tbl[12] = mk(1, 0, 0, 1, 1, 0);
        tbl[13] = mk(1, 1, 0, 1, 1, 0);
        tbl[14] = mk(1, 0, 0, 1, 1, 0);
        tbl[15] = mk(1, 1, 0, 1, 0, 0);
        tbl[16] = mk(1, 0, 0, 1, 0, 0);
        tbl[17] = mk(1, 1, 0, 1, 0, 0);
        tbl[18] = mk(1, 0, 0, 1, 0, 0);
        tbl[19] = mk(1, 1, 0, 0, 0, 1);
        tbl[20] = mk(1, 0, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 3, 0);
        tbl[22] = mk(1, 0, 0, 1, 3, 0);
        tbl[23] = mk(1, 0, 1, 0, 0, 1);
        tbl[24] = mk(1, 0, 0, 0, 0, 0);
        tbl[25] = mk(1, 0, 1, 0, 0, 0);
        tbl[26] = mk(0, 0, 1, 0, 3, 0);
        tbl[27] = mk(0, 0, 1, 0, 3, 0);

        do_reset();
        for (int i = 0; i < 28; i++) begin
            cyc(tbl[i].ge, tbl[i].vb, tbl[i].sk);
            chk($sformatf("vec%0d_anim", i), bus.animation, tbl[i].a);
            chk($sformatf("vec%0d_cnt", i), bus.counter, tbl[i].c);
            chk($sformatf("vec%0d_done", i), bus.done, tbl[i].d);
        end

        do_reset();
        full_run();

        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(4);
        chk("skip_pre_cnt", bus.counter, 2);
        cyc(1'b1, 1'b0, 1'b1);
        chk("skip_cnt", bus.counter, 0);
        chk("skip_anim", bus.animation, 0);
        chk("skip_done", bus.done, 1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("skip_done_once", bus.done, 0);

        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(6);
        chk("abort_pre_cnt", bus.counter, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("abort_anim", bus.animation, 0);
        chk("abort_cnt", bus.counter, SC);
        chk("abort_done", bus.done, 0);
        full_run();

        do_reset();
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("edge_start_anim", bus.animation, 1);
        repeat (49) cyc(1'b1, 1'b1, 1'b0);
        repeat (50) cyc(1'b1, 1'b0, 1'b0);
        ticks(3);
        chk("edge_t3_cnt", bus.counter, 3);
        ticks(1);
        chk("edge_t4_cnt", bus.counter, 2);

        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(3);
        cyc(1'b1, 1'b1, 1'b1);
        chk("sim_step_skip_done", bus.done, 1);
        chk("sim_step_skip_cnt", bus.counter, 0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        ticks(2);
        cyc(1'b0, 1'b0, 1'b1);
        chk("sim_abort_skip_done", bus.done, 0);
        chk("sim_abort_skip_cnt", bus.counter, SC);
        chk("sim_abort_skip_anim", bus.animation, 0);

        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        ticks(4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_anim", bus.animation, 0);
        chk("async_rst_cnt", bus.counter, SC);
        chk("async_rst_done", bus.done, 0);
        @(posedge clk);
        #1;
        chk("async_hold_cnt", bus.counter, SC);
        rst_n = 1'b1;
        m_act = 0; m_fin = 0; m_vprev = 0; m_t = 0; m_pulse = 0;

        vb_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            vb_r ^= ($urandom_range(0, 3) == 0);
            cyc($urandom_range(0, 149) != 0, vb_r, $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
